// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage registers.
// Used by pipe_stage_cell and pipe_stage_reg.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] PC_RST_VAL = 32'h0000_0000;
    localparam int          STATS_W    = 16;

    typedef logic [1:0] stage_idx_t;

    // Saturating increment for the statistics counters
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/pipe_stage_cell.sv
// One pipeline stage: payload and valid flops behind a rst > flush > stall > load priority.
module pipe_stage_cell
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_INSTR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic [WIDTH-1:0] q_data
);

    // Flush wins over stall so a bubble can be injected into a held pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= RST_VAL;
        end else if (flush) begin
            q_valid <= 1'b0;
            q_data  <= BUBBLE_VAL;
        end else if (!stall) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Chain of DEPTH pipeline stages with stall, flush and occupancy reporting.
// Optional stall/flush statistics counters are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               DEPTH      = 1,
    parameter logic [WIDTH-1:0] RST_VAL    = WIDTH'(PC_RST_VAL),
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_INSTR)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STATS_W-1:0]           stall_cnt,
    output logic [STATS_W-1:0]           flush_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             d_valid;
        logic [WIDTH-1:0] d_data;

        if (i == 0) begin : g_head
            assign d_valid = in_valid;
            assign d_data  = in_data;
        end else begin : g_tail
            assign d_valid = valid_q[i-1];
            assign d_data  = data_q[i-1];
        end

        pipe_stage_cell #(
            .WIDTH      (WIDTH),
            .RST_VAL    (RST_VAL),
            .BUBBLE_VAL (BUBBLE_VAL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall),
            .flush   (flush),
            .d_valid (d_valid),
            .d_data  (d_data),
            .q_valid (valid_q[i]),
            .q_data  (data_q[i])
        );
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // A stall that coincides with a flush is not counted as a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            flush_cnt <= sat_inc(flush_cnt);
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`else
    // Statistics counters are not built in this configuration
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg with DEPTH=3 and DEPTH=2 instances on shared stimulus.
// Stats checks are compiled when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_reg;

    localparam logic [31:0] RST3 = 32'hDEAD_0003;
    localparam logic [31:0] BUB3 = 32'h0000_0000;
    localparam logic [31:0] RST2 = 32'h1111_1111;
    localparam logic [31:0] BUB2 = 32'hBBBB_BBBB;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;

    logic        out_valid3, out_valid2;
    logic [31:0] out_data3, out_data2;
    logic [1:0]  occ3, occ2;
`ifdef PIPE_STAGE_STATS_EN
    logic [15:0] stall_cnt3, flush_cnt3, stall_cnt2, flush_cnt2;
    logic [15:0] exp_sc, exp_fc;
`endif

    int   checks = 0;
    int   errors = 0;
    ent_t q3[$];
    ent_t q2[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .DEPTH(3), .RST_VAL(RST3), .BUBBLE_VAL(BUB3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid3),
        .out_data  (out_data3),
        .occupancy (occ3)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt3),
        .flush_cnt (flush_cnt3)
`endif
    );

    pipe_stage_reg #(.WIDTH(32), .DEPTH(2), .RST_VAL(RST2), .BUBBLE_VAL(BUB2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_data  (out_data2),
        .occupancy (occ2)
`ifdef PIPE_STAGE_STATS_EN
        ,
        .stall_cnt (stall_cnt2),
        .flush_cnt (flush_cnt2)
`endif
    );

    function automatic logic [1:0] countValid(input ent_t q[$]);
        logic [1:0] n = '0;
        foreach (q[i]) n = n + 2'(q[i].v);
        return n;
    endfunction

    task automatic fillModels(input logic [31:0] v3, input logic [31:0] v2);
        q3.delete();
        q2.delete();
        repeat (3) q3.push_back({1'b0, v3});
        repeat (2) q2.push_back({1'b0, v2});
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // q[0] is the oldest entry, i.e. what the last stage should present
    task automatic checkOutput(input string tag);
        checkValue({tag, "/valid3"}, 32'(out_valid3), 32'(q3[0].v));
        checkValue({tag, "/data3"},  out_data3,       q3[0].d);
        checkValue({tag, "/occ3"},   32'(occ3),       32'(countValid(q3)));
        checkValue({tag, "/valid2"}, 32'(out_valid2), 32'(q2[0].v));
        checkValue({tag, "/data2"},  out_data2,       q2[0].d);
        checkValue({tag, "/occ2"},   32'(occ2),       32'(countValid(q2)));
`ifdef PIPE_STAGE_STATS_EN
        checkValue({tag, "/scnt"}, 32'(stall_cnt2), 32'(exp_sc));
        checkValue({tag, "/fcnt"}, 32'(flush_cnt2), 32'(exp_fc));
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic s, input logic f,
                                 input logic v, input logic [31:0] d);
        stall    = s;
        flush    = f;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (f) begin
            fillModels(BUB3, BUB2);
        end else if (!s) begin
            void'(q3.pop_front());
            void'(q2.pop_front());
            q3.push_back({v, d});
            q2.push_back({v, d});
        end
`ifdef PIPE_STAGE_STATS_EN
        if (f) exp_fc = (exp_fc == 16'hFFFF) ? exp_fc : exp_fc + 16'd1;
        else if (s) exp_sc = (exp_sc == 16'hFFFF) ? exp_sc : exp_sc + 16'd1;
`endif
        #1;
        checkOutput(tag);
    endtask

    // Asserts rst away from any edge, checks the async effect, holds one edge, releases
    task automatic doReset(input string tag);
        rst = 1'b1;
        #1;
        fillModels(RST3, RST2);
`ifdef PIPE_STAGE_STATS_EN
        exp_sc = '0;
        exp_fc = '0;
`endif
        checkOutput(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #2;
        doReset("reset");
        checkValue("reset_data3", out_data3, RST3);
        checkValue("reset_occ3", 32'(occ3), 32'd0);

        // Latency through three stages
        applyStimulus("lat1", 1'b0, 1'b0, 1'b1, 32'hA);
        checkValue("lat1_occ3", 32'(occ3), 32'd1);
        applyStimulus("lat2", 1'b0, 1'b0, 1'b1, 32'hB);
        checkValue("lat2_occ3", 32'(occ3), 32'd2);
        applyStimulus("lat3", 1'b0, 1'b0, 1'b1, 32'hC);
        checkValue("lat3_data3", out_data3, 32'hA);
        checkValue("lat3_occ3", 32'(occ3), 32'd3);
        applyStimulus("lat4", 1'b0, 1'b0, 1'b1, 32'hD);
        checkValue("lat4_data3", out_data3, 32'hB);
        applyStimulus("lat5", 1'b0, 1'b0, 1'b1, 32'hE);
        checkValue("lat5_data3", out_data3, 32'hC);

        // Asynchronous reset mid-stream, released while stalled
        stall = 1'b1;
        doReset("midreset");
        checkValue("midreset_valid3", 32'(out_valid3), 32'd0);
        applyStimulus("rststall", 1'b1, 1'b0, 1'b1, 32'h99);
        checkValue("rststall_data2", out_data2, RST2);

        // Stall holds contents, release resumes in order
        applyStimulus("fill1", 1'b0, 1'b0, 1'b1, 32'h1);
        applyStimulus("fill2", 1'b0, 1'b0, 1'b1, 32'h2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("stall", 1'b1, 1'b0, 1'b1, 32'h40 + 32'(i));
            checkValue("stall_data2", out_data2, 32'h1);
        end
        applyStimulus("resume1", 1'b0, 1'b0, 1'b1, 32'h3);
        checkValue("resume1_data2", out_data2, 32'h2);
        applyStimulus("resume2", 1'b0, 1'b0, 1'b1, 32'h4);
        checkValue("resume2_data2", out_data2, 32'h3);

        // Flush overrides stall
        applyStimulus("full1", 1'b0, 1'b0, 1'b1, 32'h1);
        applyStimulus("full2", 1'b0, 1'b0, 1'b1, 32'h2);
        applyStimulus("flushstall", 1'b1, 1'b1, 1'b1, 32'h7);
        checkValue("flush_data2", out_data2, BUB2);
        checkValue("flush_occ2", 32'(occ2), 32'd0);

        // Invalid inputs still shift their payload
        applyStimulus("bub1", 1'b0, 1'b0, 1'b1, 32'h5);
        applyStimulus("bub2", 1'b0, 1'b0, 1'b0, 32'h6);
        checkValue("bub2_valid2", 32'(out_valid2), 32'd1);
        checkValue("bub2_data2", out_data2, 32'h5);
        applyStimulus("bub3", 1'b0, 1'b0, 1'b0, 32'h0);
        checkValue("bub3_valid2", 32'(out_valid2), 32'd0);
        checkValue("bub3_data2", out_data2, 32'h6);

`ifdef PIPE_STAGE_STATS_EN
        doReset("stats_clear");
        repeat (3) applyStimulus("stats_stall", 1'b1, 1'b0, 1'b1, 32'h8);
        repeat (2) applyStimulus("stats_flush", 1'b0, 1'b1, 1'b1, 32'h9);
        checkValue("stats_scnt", 32'(stall_cnt3), 32'd3);
        checkValue("stats_fcnt", 32'(flush_cnt3), 32'd2);
        doReset("stats_rst");
        checkValue("stats_rst_scnt", 32'(stall_cnt3), 32'd0);
        stall = 1'b1;
        flush = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        checkValue("stats_sat", 32'(stall_cnt2), 32'h0000_FFFF);
        checkValue("stats_sat_fcnt", 32'(flush_cnt2), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
